// File: rtl/pulse_period_checker.sv
// pulse_period_checker
// Monitors a periodic single-cycle strobe in the clk domain and measures the
// number of clocks between rising edges. Declares lock after LOCK_CNT
// consecutive periods equal to EXP_PERIOD, and pulses err on a period mismatch
// or when the strobe disappears long enough for the counter to saturate.
// Optional build macro PPC_ERR_COUNT_EN adds an 8-bit saturating err_count output.
module pulse_period_checker #(
  parameter int EXP_PERIOD = 3,
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
`ifdef PPC_ERR_COUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_PERIOD);
  localparam logic [3:0]       LOCK_VAL = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

  state_t           state_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       match_q;
  logic [CNT_W-1:0] period_q;
  logic             period_valid_q;
  logic             locked_q;
  logic             err_q;

  logic             pulse_edge;
  logic             cnt_sat;
  logic             cnt_match;
  logic [3:0]       match_inc;

  // A level held high yields exactly one edge; cnt_q is the clock count since
  // the previous edge, so edges N clocks apart see cnt_q == N.
  assign pulse_edge = pulse_in & ~pulse_q;
  assign cnt_sat    = (cnt_q == CNT_MAX);
  assign cnt_match  = (cnt_q == EXP_VAL);
  assign match_inc  = match_q + 4'd1;

  // Edge history and the saturating period counter (restarts at 1 on each edge).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= pulse_in;
      if (!en || state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else if (pulse_edge) begin
        cnt_q <= CNT_ONE;
      end else if (!cnt_sat) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // Lock/measure state machine with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      match_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;
      if (!en) begin
        // Disable is silent: no err, period keeps its last value.
        state_q  <= ST_IDLE;
        locked_q <= 1'b0;
        match_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            match_q <= '0;
            state_q <= ST_HUNT;
          end
          ST_HUNT: begin
            // The first edge is only a reference; nothing is reported.
            if (pulse_edge) begin
              state_q <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            // An edge coinciding with saturation still counts as an edge.
            if (pulse_edge) begin
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              if (cnt_match) begin
                match_q <= match_inc;
                if (match_inc == LOCK_VAL) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                match_q <= '0;
                err_q   <= 1'b1;
              end
            end else if (cnt_sat) begin
              err_q    <= 1'b1;
              match_q  <= '0;
              locked_q <= 1'b0;
              state_q  <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            if (pulse_edge) begin
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              if (!cnt_match) begin
                // This edge becomes the new reference for re-acquisition.
                err_q    <= 1'b1;
                locked_q <= 1'b0;
                match_q  <= '0;
                state_q  <= ST_MEASURE;
              end
            end else if (cnt_sat) begin
              err_q    <= 1'b1;
              match_q  <= '0;
              locked_q <= 1'b0;
              state_q  <= ST_HUNT;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            match_q  <= '0;
          end
        endcase
      end
    end
  end

`ifdef PPC_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // Saturating count of err pulses; only reset clears it, disable does not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_q <= '0;
    end else if (err_q && err_count_q != 8'hFF) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err          = err_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed testbench for pulse_period_checker (default parameters).
module tb_pulse_period_checker;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       pulse_in;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       err;
`ifdef PPC_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int checks;
  int failures;

  pulse_period_checker #(
    .EXP_PERIOD(3),
    .CNT_W     (8),
    .LOCK_CNT  (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .pulse_in    (pulse_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .err         (err)
`ifdef PPC_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       p;
    logic       pv;
    logic       lk;
    logic       er;
    logic [7:0] per;
  } vec_t;

  vec_t tbl[$];

  function automatic void push(input logic e, input logic p, input logic pv,
                               input logic lk, input logic er, input logic [7:0] per);
    vec_t v;
    v.en = e; v.p = p; v.pv = pv; v.lk = lk; v.er = er; v.per = per;
    tbl.push_back(v);
  endfunction

  // n strobe-low cycles with no report expected
  function automatic void quiet(input int n, input logic lk, input logic [7:0] per);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, lk, 1'b0, per);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic apply_reset;
    reset_n  = 1'b0;
    en       = 1'b0;
    pulse_in = 1'b0;
    tick;
    reset_n  = 1'b1;
  endtask

  // Enable from IDLE and drive a divide-by-3 strobe for 5 edges; lock on the 5th.
  task automatic lock_up(input string tag);
    en = 1'b1; pulse_in = 1'b0; tick;
    for (int e = 0; e < 5; e++) begin
      pulse_in = 1'b1; tick;
      check($sformatf("%s_e%0d_pv", tag, e), int'(period_valid), (e == 0) ? 0 : 1);
      if (e > 0) check($sformatf("%s_e%0d_period", tag, e), int'(period), 3);
      check($sformatf("%s_e%0d_err", tag, e), int'(err), 0);
      check($sformatf("%s_e%0d_locked", tag, e), int'(locked), (e == 4) ? 1 : 0);
      pulse_in = 1'b0; tick; tick;
    end
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    pulse_in = 1'b0;
    tick; tick;
    check("rst_period", int'(period), 0);
    check("rst_pv", int'(period_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    reset_n = 1'b1;

    // Lock on divide-by-3, early edge, relock, then a period-4 strobe.
    push(1, 0, 0, 0, 0, 0);
    push(1, 1, 0, 0, 0, 0);
    quiet(2, 0, 0);
    push(1, 1, 1, 0, 0, 3); quiet(2, 0, 3);
    push(1, 1, 1, 0, 0, 3); quiet(2, 0, 3);
    push(1, 1, 1, 0, 0, 3); quiet(2, 0, 3);
    push(1, 1, 1, 1, 0, 3); quiet(2, 1, 3);
    push(1, 1, 1, 1, 0, 3); quiet(1, 1, 3);
    push(1, 1, 1, 0, 1, 2); quiet(2, 0, 2);
    push(1, 1, 1, 0, 0, 3); quiet(2, 0, 3);
    push(1, 1, 1, 0, 0, 3); quiet(2, 0, 3);
    push(1, 1, 1, 0, 0, 3); quiet(2, 0, 3);
    push(1, 1, 1, 1, 0, 3); quiet(3, 1, 3);
    push(1, 1, 1, 0, 1, 4); quiet(3, 0, 4);
    push(1, 1, 1, 0, 1, 4); quiet(3, 0, 4);
    push(1, 1, 1, 0, 1, 4); quiet(1, 0, 4);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; pulse_in = tbl[i].p;
      tick;
      check($sformatf("row%0d_pv", i), int'(period_valid), int'(tbl[i].pv));
      check($sformatf("row%0d_locked", i), int'(locked), int'(tbl[i].lk));
      check($sformatf("row%0d_err", i), int'(err), int'(tbl[i].er));
      check($sformatf("row%0d_period", i), int'(period), int'(tbl[i].per));
    end
`ifdef PPC_ERR_COUNT_EN
    check("err_count_after_table", int'(err_count), 4);
`endif

    // Loss of strobe while locked: single err once the counter saturates.
    apply_reset;
    lock_up("to");
    seen = 0;
    for (int j = 3; j <= 254; j++) begin
      tick;
      if (err || period_valid) seen++;
    end
    check("to_early_err", seen, 0);
    tick;
    check("to_err", int'(err), 1);
    check("to_locked", int'(locked), 0);
    check("to_pv", int'(period_valid), 0);
    tick;
    check("to_err_once", int'(err), 0);
    // Next edge re-enters from HUNT: no report; then held high gives no edges.
    pulse_in = 1'b1; tick;
    check("hunt_edge_pv", int'(period_valid), 0);
    seen = 0;
    for (int j = 1; j <= 253; j++) begin
      tick;
      if (err || period_valid) seen++;
    end
    check("held_high_quiet", seen, 0);
    pulse_in = 1'b0; tick;
    check("pre_sat_quiet", int'(err), 0);
    // Edge exactly when the counter is saturated: edge wins, mismatch of 255.
    pulse_in = 1'b1; tick;
    check("sat_edge_pv", int'(period_valid), 1);
    check("sat_edge_period", int'(period), 255);
    check("sat_edge_err", int'(err), 1);
    pulse_in = 1'b0; tick;
    check("sat_edge_err_once", int'(err), 0);

    // Disable while locked: silent drop of lock, period holds, then relock.
    apply_reset;
    lock_up("en");
    en = 1'b0; tick;
    check("dis_locked", int'(locked), 0);
    check("dis_err", int'(err), 0);
    check("dis_period", int'(period), 3);
    seen = 0;
    for (int j = 0; j < 4; j++) begin
      tick;
      if (err || period_valid || locked) seen++;
    end
    check("dis_quiet", seen, 0);
    check("dis_period_hold", int'(period), 3);
    lock_up("relock");

    // Asynchronous reset mid-period while locked.
    pulse_in = 1'b0; tick;
    #2 reset_n = 1'b0;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_pv", int'(period_valid), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_err", int'(err), 0);
    tick; tick;
    check("arst_hold_locked", int'(locked), 0);
    reset_n = 1'b1;
    lock_up("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
